sha256_job_arbiter: RTL

SHA256_JOB_ARBITER -- requirements
Module: sha256_job_arbiter

---
 rtl/sha256_ctrl_pkg.sv | 22 ++
 rtl/sha256_rr_pick.sv | 36 +++
 rtl/sha256_job_arbiter.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/sha256_ctrl_pkg.sv
// Shared definitions for the SHA-256 job control slice: defaults, widths and FSM encoding.
package sha256_ctrl_pkg;

   localparam int unsigned DEF_NUM_REQ        = 4;
   localparam int unsigned DEF_TIMEOUT_CYCLES = 4096;
   localparam int unsigned ADDR_W             = 16;
   localparam int unsigned WD_W               = 16;

   // Arbiter FSM encoding, kept as plain constants for compatibility with older tools.
   typedef logic [2:0] state_t;
   localparam state_t S_IDLE      = 3'd0;
   localparam state_t S_LAUNCH    = 3'd1;
   localparam state_t S_WAIT_BUSY = 3'd2;
   localparam state_t S_WAIT_DONE = 3'd3;
   localparam state_t S_COMPLETE  = 3'd4;

   // Index width for a requester count; never narrower than one bit.
   function automatic int unsigned idx_width(input int unsigned n);
      return (n > 1) ? $clog2(n) : 1;
   endfunction

endpackage

// File: rtl/sha256_rr_pick.sv
// Combinational round-robin pick: the first requester after last_owner (wrapping) wins.
module sha256_rr_pick
   import sha256_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ = DEF_NUM_REQ,
   parameter int unsigned IDX_W   = idx_width(DEF_NUM_REQ)
) (
   input  logic [NUM_REQ-1:0] req,
   input  logic [IDX_W-1:0]   last_owner,
   output logic [NUM_REQ-1:0] winner,
   output logic               valid
);

   int unsigned       pos_sum;
   logic [IDX_W-1:0]  pos;

   // Scan from last_owner+1 upward, wrapping, and keep the first requester found.
   always_comb begin
      winner  = '0;
      valid   = 1'b0;
      pos_sum = 0;
      pos     = '0;
      for (int unsigned i = 1; i <= NUM_REQ; i++) begin
         pos_sum = 32'(last_owner) + i;
         if (pos_sum >= NUM_REQ) begin
            pos_sum = pos_sum - NUM_REQ;
         end
         pos = IDX_W'(pos_sum);
         if (!valid && req[pos]) begin
            winner[pos] = 1'b1;
            valid       = 1'b1;
         end
      end
   end

endmodule

// File: rtl/sha256_job_arbiter.sv
// Round-robin front end handing one job at a time to a shared SHA-256 core, with a per-job
// watchdog. All outputs come straight from flops.
module sha256_job_arbiter
   import sha256_ctrl_pkg::*;
#(
   parameter int unsigned NUM_REQ        = DEF_NUM_REQ,
   parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
   input  logic                           clk,
   input  logic                           reset_n,
   input  logic [NUM_REQ-1:0]             req,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_msg_addr,
   input  logic [NUM_REQ-1:0][ADDR_W-1:0] req_out_addr,
   output logic [NUM_REQ-1:0]             gnt,
   output logic [NUM_REQ-1:0]             cmp,
   output logic                           cmp_err,
   output logic                           core_start,
   output logic [ADDR_W-1:0]              core_message_addr,
   output logic [ADDR_W-1:0]              core_output_addr,
   input  logic                           core_done,
   output logic                           busy
);

   localparam int unsigned     IDX_W    = idx_width(NUM_REQ);
   localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT_CYCLES);
   localparam logic [WD_W-1:0] WD_MAX   = '1;

   state_t               state_q, state_d;
   logic [IDX_W-1:0]     owner_q, owner_d;
   logic [IDX_W-1:0]     last_q, last_d;
   logic [WD_W-1:0]      wd_q, wd_d, wd_inc;
   logic [NUM_REQ-1:0]   gnt_q, gnt_d;
   logic [NUM_REQ-1:0]   cmp_q, cmp_d;
   logic                 cmp_err_q, cmp_err_d;
   logic                 start_q, start_d;
   logic                 busy_q;
   logic [ADDR_W-1:0]    msg_q, msg_d;
   logic [ADDR_W-1:0]    out_q, out_d;

   logic [NUM_REQ-1:0]   win_oh;
   logic                 win_valid;
   logic [IDX_W-1:0]     win_idx;
   logic [NUM_REQ-1:0]   owner_oh;

   sha256_rr_pick #(
      .NUM_REQ (NUM_REQ),
      .IDX_W   (IDX_W)
   ) u_pick (
      .req        (req),
      .last_owner (last_q),
      .winner     (win_oh),
      .valid      (win_valid)
   );

   // Binary index of the one-hot winner, used to latch its addresses.
   always_comb begin
      win_idx = '0;
      for (int unsigned i = 0; i < NUM_REQ; i++) begin
         if (win_oh[i]) begin
            win_idx = IDX_W'(i);
         end
      end
   end

   assign owner_oh = NUM_REQ'(1) << owner_q;
   assign wd_inc   = (wd_q == WD_MAX) ? wd_q : wd_q + 1'b1;

   // Next-state and next-output decode. Pulses are computed one cycle ahead so that gnt shows
   // during LAUNCH, core_start during the first WAIT_BUSY cycle and cmp during COMPLETE.
   always_comb begin
      state_d   = state_q;
      owner_d   = owner_q;
      last_d    = last_q;
      wd_d      = wd_q;
      gnt_d     = '0;
      cmp_d     = '0;
      cmp_err_d = 1'b0;
      start_d   = 1'b0;
      msg_d     = msg_q;
      out_d     = out_q;
      case (state_q)
         S_IDLE: begin
            // A core that is not idle blocks every grant.
            if (win_valid && core_done) begin
               state_d = S_LAUNCH;
               owner_d = win_idx;
               gnt_d   = win_oh;
               msg_d   = req_msg_addr[win_idx];
               out_d   = req_out_addr[win_idx];
               wd_d    = '0;
            end
         end
         S_LAUNCH: begin
            state_d = S_WAIT_BUSY;
            start_d = 1'b1;
         end
         S_WAIT_BUSY: begin
            wd_d = wd_inc;
            // The watchdog wins over a core that only now starts running.
            if (wd_inc >= WD_LIMIT) begin
               state_d   = S_COMPLETE;
               cmp_d     = owner_oh;
               cmp_err_d = 1'b1;
            end else if (!core_done) begin
               state_d = S_WAIT_DONE;
            end
         end
         S_WAIT_DONE: begin
            wd_d = wd_inc;
            // A genuine finish wins over a watchdog expiring in the same cycle.
            if (core_done) begin
               state_d = S_COMPLETE;
               cmp_d   = owner_oh;
            end else if (wd_inc >= WD_LIMIT) begin
               state_d   = S_COMPLETE;
               cmp_d     = owner_oh;
               cmp_err_d = 1'b1;
            end
         end
         S_COMPLETE: begin
            state_d = S_IDLE;
            last_d  = owner_q;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and output registers; reset drops any job in flight without a completion.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_q   <= S_IDLE;
         owner_q   <= '0;
         last_q    <= IDX_W'(NUM_REQ - 1);
         wd_q      <= '0;
         gnt_q     <= '0;
         cmp_q     <= '0;
         cmp_err_q <= 1'b0;
         start_q   <= 1'b0;
         busy_q    <= 1'b0;
         msg_q     <= '0;
         out_q     <= '0;
      end else begin
         state_q   <= state_d;
         owner_q   <= owner_d;
         last_q    <= last_d;
         wd_q      <= wd_d;
         gnt_q     <= gnt_d;
         cmp_q     <= cmp_d;
         cmp_err_q <= cmp_err_d;
         start_q   <= start_d;
         busy_q    <= (state_d != S_IDLE);
         msg_q     <= msg_d;
         out_q     <= out_d;
      end
   end

   assign gnt               = gnt_q;
   assign cmp               = cmp_q;
   assign cmp_err           = cmp_err_q;
   assign core_start        = start_q;
   assign core_message_addr = msg_q;
   assign core_output_addr  = out_q;
   assign busy              = busy_q;

endmodule
